// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670-style camera bus (emulator and capture side).
package cam_pkg;
  localparam int ROW_W = 9;
  localparam int COL_W = 10;

  typedef logic [14:0] rgb555_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } cam_state_e;

  function automatic logic [7:0] hi_byte(input rgb555_t p);
    return {1'b0, p[14:8]};
  endfunction

  function automatic logic [7:0] lo_byte(input rgb555_t p);
    return p[7:0];
  endfunction
endpackage

// File: rtl/cam_pclk_gen.sv
// Divides clk into the camera pclk and flags the clk cycles in which pclk is about to toggle.
module cam_pclk_gen #(
  parameter int PCLK_HALF = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int CNT_W = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pclk_q, pclk_d;
  logic             tick;

  always_comb begin
    tick   = (cnt_q == CNT_W'(PCLK_HALF - 1));
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    pclk_d = tick ? ~pclk_q : pclk_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pclk_q <= pclk_d;
    end
  end

  assign pclk_o      = pclk_q;
  assign rise_tick_o = tick & ~pclk_q;
  assign fall_tick_o = tick &  pclk_q;
endmodule

// File: rtl/cam_emulator.sv
// OV7670-style RGB555 transmitter: frame/line timing FSM, pixel fetch and byte serialisation.
module cam_emulator
  import cam_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_LEN = 3,
  parameter int V_BACK    = 17,
  parameter int V_FRONT   = 10,
  parameter int PCLK_HALF = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [14:0]      rgb555,
  output logic             pix_rd,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             pclk,
  output logic             vsync,
  output logic             href,
  output logic [7:0]       data,
  output logic             frame_start,
  output logic             busy
);
  localparam int BYTES     = 2 * H_ACTIVE;
  localparam int LINE_LEN  = BYTES + H_BLANK;
  localparam int MAX_AB    = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int MAX_CD    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int H_W       = $clog2(LINE_LEN + 1);
  localparam int V_W       = $clog2(MAX_LINES + 1);

  logic rise_tick, fall_tick;

  cam_pclk_gen #(.PCLK_HALF(PCLK_HALF)) u_pclk (
    .clk_i       (clk),
    .rst_i       (rst),
    .pclk_o      (pclk),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  cam_state_e       state_q, state_d;
  logic [V_W-1:0]   line_q, line_d, last_line;
  logic [H_W-1:0]   h_q, h_d;
  logic             vsync_q, vsync_d, href_q, href_d;
  logic [7:0]       data_q, data_d, lo_q, lo_d;
  rgb555_t          pix_q, pix_d, cur_pix;
  logic             pix_vld_q, pix_vld_d, pix_rd_q, pix_rd_d, fs_q, fs_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    h_d       = h_q;
    vsync_d   = vsync_q;
    href_d    = href_q;
    data_d    = data_q;
    lo_d      = lo_q;
    pix_rd_d  = 1'b0;
    row_d     = row_q;
    col_d     = col_q;
    fs_d      = 1'b0;
    pix_vld_d = pix_rd_q;
    // Bypass lets a pixel arriving this cycle be emitted immediately when PCLK_HALF=1.
    cur_pix   = pix_vld_q ? rgb555 : pix_q;
    pix_d     = cur_pix;
    last_line = '0;
    case (state_q)
      ST_VSYNC:  last_line = V_W'(VSYNC_LEN - 1);
      ST_VBACK:  last_line = V_W'(V_BACK - 1);
      ST_ACTIVE: last_line = V_W'(V_ACTIVE - 1);
      ST_VFRONT: last_line = V_W'(V_FRONT - 1);
      default:   last_line = '0;
    endcase

    if (fall_tick) begin
      if (state_q == ST_IDLE) begin
        if (en) begin
          state_d = ST_VSYNC;
          line_d  = '0;
          h_d     = '0;
        end
      end else if (h_q == H_W'(LINE_LEN - 1)) begin
        h_d = '0;
        if (line_q == last_line) begin
          line_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            ST_VFRONT: state_d = en ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          line_d = line_q + V_W'(1);
        end
      end else begin
        h_d = h_q + H_W'(1);
      end

      // Outputs describe the slot just entered, so they change only on fall_tick.
      fs_d    = (state_d == ST_VSYNC) && ((state_q == ST_IDLE) || (state_q == ST_VFRONT));
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && (h_d < H_W'(BYTES));
      data_d  = '0;
      if (href_d) begin
        if (!h_d[0]) begin
          data_d = hi_byte(cur_pix);
          lo_d   = lo_byte(cur_pix);
        end else begin
          data_d = lo_q;
        end
      end

      if (h_d == H_W'(LINE_LEN - 1)) begin
        if (state_d == ST_VBACK && line_d == V_W'(V_BACK - 1)) begin
          pix_rd_d = 1'b1;
          row_d    = '0;
          col_d    = '0;
        end else if (state_d == ST_ACTIVE && line_d < V_W'(V_ACTIVE - 1)) begin
          pix_rd_d = 1'b1;
          row_d    = ROW_W'(line_d) + ROW_W'(1);
          col_d    = '0;
        end
      end else if (href_d && !h_d[0] && h_d < H_W'(BYTES - 2)) begin
        pix_rd_d = 1'b1;
        row_d    = ROW_W'(line_d);
        col_d    = COL_W'(h_d >> 1) + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      h_q       <= '0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
      lo_q      <= '0;
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
      pix_rd_q  <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      h_q       <= h_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      data_q    <= data_d;
      lo_q      <= lo_d;
      pix_q     <= pix_d;
      pix_vld_q <= pix_vld_d;
      pix_rd_q  <= pix_rd_d;
      row_q     <= row_d;
      col_q     <= col_d;
      fs_q      <= fs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(rise_tick && fall_tick));
  end

  assign pix_rd      = pix_rd_q;
  assign row         = row_q;
  assign col         = col_q;
  assign vsync       = vsync_q;
  assign href        = href_q;
  assign data        = data_q;
  assign frame_start = fs_q;
  assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_cam_emulator.sv
// Bench for cam_emulator: slot-arithmetic reference model, per-cycle compare, literal pins.
module tb_cam_emulator;
  localparam int HA = 4, VA = 3, HB = 3, VS = 1, VB = 1, VF = 1, PH = 2;
  localparam int L     = 2 * HA + HB;
  localparam int FRAME = L * (VS + VB + VA + VF);

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [14:0] rgb555 = '0;
  logic        pix_rd, pclk, vsync, href, frame_start, busy;
  logic [8:0]  row;
  logic [9:0]  col;
  logic [7:0]  data;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  cam_emulator #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LEN(VS),
    .V_BACK(VB), .V_FRONT(VF), .PCLK_HALF(PH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rgb555(rgb555), .pix_rd(pix_rd),
    .row(row), .col(col), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .frame_start(frame_start), .busy(busy)
  );

  function automatic logic [14:0] pattern(input int r, input int c);
    return 15'(((r & 31) << 10) | ((c & 31) << 5) | 'h15);
  endfunction

  // Frame source: 1-clk read latency.
  always @(posedge clk) if (pix_rd) rgb555 <= pattern(int'(row), int'(col));

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: time since reset and a linear slot index within the frame.
  int t = 0, slot = 0, m_h = 0, line_i = 0, a_i = 0;
  bit run = 0;
  logic       m_pclk = 0, m_vsync = 0, m_href = 0, m_pixrd = 0, m_fs = 0, m_busy = 0;
  logic [7:0] m_data = '0;
  logic [8:0] m_row = '0;
  logic [9:0] m_col = '0;
  logic [14:0] p;

  always @(posedge clk) begin
    if (!rst) begin
      t = 0; run = 0; slot = 0; m_h = 0;
      m_pclk = 0; m_vsync = 0; m_href = 0; m_data = '0; m_pixrd = 0;
      m_row = '0; m_col = '0; m_fs = 0; m_busy = 0;
    end else begin
      t++;
      m_pclk  = ((t / PH) % 2) == 1;
      m_pixrd = 0;
      m_fs    = 0;
      if (t % (2 * PH) == 0) begin
        if (!run) begin
          if (en) begin run = 1; slot = 0; m_fs = 1; end
        end else begin
          slot++;
          if (slot == FRAME) begin
            if (en) begin slot = 0; m_fs = 1; end
            else run = 0;
          end
        end
        line_i  = slot / L;
        m_h     = slot % L;
        a_i     = line_i - (VS + VB);
        m_busy  = run;
        m_vsync = run && (line_i < VS);
        m_href  = run && (a_i >= 0) && (a_i < VA) && (m_h < 2 * HA);
        m_data  = '0;
        if (m_href) begin
          p = pattern(a_i, m_h / 2);
          m_data = (m_h % 2 == 1) ? 8'(p & 15'h00FF) : 8'(p >> 8);
        end
        if (run && m_h == L - 1 && a_i + 1 >= 0 && a_i + 1 < VA) begin
          m_pixrd = 1; m_row = 9'(a_i + 1); m_col = '0;
        end else if (m_href && m_h % 2 == 0 && m_h / 2 < HA - 1) begin
          m_pixrd = 1; m_row = 9'(a_i); m_col = 10'(m_h / 2 + 1);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("pclk",        int'(pclk),        int'(m_pclk));
    check("vsync",       int'(vsync),       int'(m_vsync));
    check("href",        int'(href),        int'(m_href));
    check("data",        int'(data),        int'(m_data));
    check("pix_rd",      int'(pix_rd),      int'(m_pixrd));
    check("row",         int'(row),         int'(m_row));
    check("col",         int'(col),         int'(m_col));
    check("frame_start", int'(frame_start), int'(m_fs));
    check("busy",        int'(busy),        int'(m_busy));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int tt, nf, nh, cnt, k;
    bit prev_pclk, found;

    rst = 1'b0; en = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_pclk", int'(pclk), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_data", int'(data), 0);
    rst = 1'b1;

    @(posedge clk); #1; check("pin_pclk_t1", int'(pclk), 0);
    @(posedge clk); #1; check("pin_pclk_t2", int'(pclk), 1);
    repeat (2) @(posedge clk); #1;
    check("pin_vsync_t4", int'(vsync), 1);
    check("pin_fs_t4", int'(frame_start), 1);
    @(posedge clk); #1; check("pin_fs_t5", int'(frame_start), 0);

    tt = 5; nf = 0; nh = 0; prev_pclk = pclk;
    while (tt < 268) begin
      @(posedge clk); #1; tt++;
      if (pix_rd) begin
        check("fetch_row", int'(row), nf / HA);
        check("fetch_col", int'(col), nf % HA);
        nf++;
      end
      if (pclk && !prev_pclk && href) nh++;
      prev_pclk = pclk;
      if (tt == 152) check("pin_byte_hi", int'(data), 'h04);
      if (tt == 156) check("pin_byte_lo", int'(data), 'h55);
    end
    check("fetch_count", nf, 12);
    check("href_rises", nh, 24);
    repeat (200) @(negedge clk);

    // en dropped mid-active: frame must finish, then stay idle.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (href) found = 1;
    end
    check("wait_href_en", int'(found), 1);
    en = 1'b0;
    repeat (300) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pix_rd) cnt++;
    end
    check("idle_fetches", cnt, 0);
    check("idle_busy", int'(busy), 0);
    check("idle_vsync", int'(vsync), 0);
    en = 1'b1;
    found = 0; k = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #1; k++;
      if (frame_start) found = 1;
    end
    check("fs_after_en", int'(found), 1);
    check("fs_latency_ok", int'(k <= 2 * PH + 1), 1);

    // Reset while emitting col 2 of an active line.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (href && m_href && m_h == 4) found = 1;
    end
    check("wait_col2", int'(found), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_href", int'(href), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_pclk", int'(pclk), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (pix_rd) found = 1;
    end
    check("restart_fetch", int'(found), 1);
    check("restart_row", int'(row), 0);
    check("restart_col", int'(col), 0);

    // Random en toggling with occasional resets.
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) en = ~en;
      if ($urandom_range(0, 899) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst = 1'b1;
      end
    end
    en = 1'b1;
    repeat (300) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
